lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the core execute stage and wide_ram (14-bit byte address, 32-bit data, 4 byte WEs).

---
 rtl/lsu_mem_ctrl_if.sv | 32 +++
 rtl/lsu_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Core/RAM-facing bundle of the load/store unit; slave = LSU, master = core plus RAM side.
// Unshifted byte lanes: RAM aligns write data/enables and right-justifies read data by mem_addr[1:0].
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [3:0]        mem_byte_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we, mem_byte_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we, mem_byte_we
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding RV32I load/store unit in front of wide_ram; LSU_MISALIGN_TRAP_EN traps misaligned H/W.
// Latency: error resp T+1, store resp T+2, load resp T+2+RD_LAT after accept at edge T.
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse the consumer must take.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] LP_CNT_INIT = 2'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [2:0]        r_f3;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_bwe;
    logic [31:0]       r_rdata;
    logic [1:0]        r_cnt;

    logic              w_accept;
    logic              w_f3_ok;
    logic              w_range_ok;
    logic              w_err;
    logic [3:0]        w_bwe;
    logic [31:0]       w_ext;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
    assign w_range_ok = (bus.req_addr[31:ADDR_W] == '0);

    always_comb begin
        w_f3_ok = 1'b0;
        w_bwe   = 4'b0000;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'b000:  begin w_f3_ok = 1'b1; w_bwe = 4'b0001; end
                3'b001:  begin w_f3_ok = 1'b1; w_bwe = 4'b0011; end
                3'b010:  begin w_f3_ok = 1'b1; w_bwe = 4'b1111; end
                default: w_f3_ok = 1'b0;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_err = !w_f3_ok || !w_range_ok || w_misalign;
`else
    // Misaligned accesses go through; the RAM drops bytes beyond the word boundary.
    assign w_err = !w_f3_ok || !w_range_ok;
`endif

    always_comb begin
        w_ext = bus.mem_rdata;
        case (r_f3)
            3'b000:  w_ext = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            3'b100:  w_ext = {24'h0, bus.mem_rdata[7:0]};
            3'b001:  w_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            3'b101:  w_ext = {16'h0, bus.mem_rdata[15:0]};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req_valid) w_next = w_err ? S_RESP : S_ACCESS;
            S_ACCESS: w_next = r_we ? S_RESP : S_WAIT;
            S_WAIT:   if (r_cnt == 2'd0) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (r_state == S_IDLE);
        bus.mem_addr    = r_mem_addr;
        bus.mem_wdata   = r_mem_wdata;
        bus.mem_we      = (r_state == S_ACCESS) && r_we;
        bus.mem_byte_we = (r_state == S_ACCESS) ? r_bwe : 4'b0000;
        bus.resp_valid  = (r_state == S_RESP);
        bus.resp_err    = (r_state == S_RESP) && r_err;
        bus.resp_rdata  = (r_state == S_RESP) ? r_rdata : 32'h0;
    end

    // Rejected requests never touch the RAM-facing registers, so mem_addr keeps its last legal value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_bwe       <= 4'b0000;
            r_rdata     <= 32'h0;
            r_cnt       <= 2'd0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_f3    <= bus.req_funct3;
                r_err   <= w_err;
                r_rdata <= 32'h0;
                if (!w_err) begin
                    r_mem_addr  <= bus.req_addr[ADDR_W-1:0];
                    r_mem_wdata <= bus.req_wdata;
                    r_bwe       <= w_bwe;
                end
            end
            if ((r_state == S_ACCESS) && !r_we) begin
                r_cnt <= LP_CNT_INIT;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt == 2'd0) begin
                    r_rdata <= w_ext;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench: instance A (RD_LAT=1) with a byte RAM model, instance B (RD_LAT=3) for latency and mid-op reset.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(14)) ifa ();
    lsu_mem_ctrl_if #(.ADDR_W(14)) ifb ();

    lsu_mem_ctrl #(.ADDR_W(14), .RD_LAT(1)) dut_a (.i_clk(clk), .i_rst_n(rst_a_n), .bus(ifa.slave));
    lsu_mem_ctrl #(.ADDR_W(14), .RD_LAT(3)) dut_b (.i_clk(clk), .i_rst_n(rst_b_n), .bus(ifb.slave));

    logic [7:0]  mem [0:16383];
    logic [31:0] pa0;
    logic [31:0] pb0, pb1, pb2;
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] rd(input logic [13:0] a);
        logic [31:0] d;
        d = 32'h0;
        for (int i = 0; i < 4; i++)
            if (int'(a[1:0]) + i < 4) d[i*8 +: 8] = mem[a + 14'(i)];
        return d;
    endfunction

    always @(posedge clk) begin
        if (ifa.mem_we)
            for (int i = 0; i < 4; i++)
                if (ifa.mem_byte_we[i] && (int'(ifa.mem_addr[1:0]) + i < 4))
                    mem[ifa.mem_addr + 14'(i)] = ifa.mem_wdata[i*8 +: 8];
    end

    always @(posedge clk) begin
        pa0 <= rd(ifa.mem_addr);
        pb0 <= rd(ifb.mem_addr);
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ifa.mem_rdata = pa0;
    assign ifb.mem_rdata = pb2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on A and observe 10 cycles: response cycle, data, strobes.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output int we_cnt, output logic [3:0] bwe1);
        lat = -1; rdata = 32'hx; err = 1'bx; we_cnt = 0; bwe1 = 4'hx;
        @(negedge clk);
        ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_funct3 = f3;
        ifa.req_addr = addr; ifa.req_wdata = wdata;
        @(posedge clk);
        #1 ifa.req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bwe1 = ifa.mem_byte_we;
            if (ifa.mem_we) we_cnt++;
            if (ifa.resp_valid && lat < 0) begin
                lat = c; rdata = ifa.resp_rdata; err = ifa.resp_err;
            end
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_we, input logic [3:0] exp_bwe);
        int lat, wc;
        logic [31:0] rdv;
        logic e;
        logic [3:0] b;
        do_req(we, f3, addr, wdata, lat, rdv, e, wc, b);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, rdv, exp_rd);
        chk({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
        chk({tag, "_wecnt"}, wc, exp_we);
        chk({tag, "_bwe"}, {28'h0, b}, {28'h0, exp_bwe});
    endtask

    initial begin
        int lat, cnt;
        logic addr_ok;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        ifa.req_valid = 0; ifa.req_we = 0; ifa.req_funct3 = 0; ifa.req_addr = 0; ifa.req_wdata = 0;
        ifb.req_valid = 0; ifb.req_we = 0; ifb.req_funct3 = 0; ifb.req_addr = 0; ifb.req_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, ifa.req_ready}, 32'h1);
        chk("rst_rvalid", {31'h0, ifa.resp_valid}, 32'h0);
        chk("rst_err", {31'h0, ifa.resp_err}, 32'h0);
        chk("rst_rdata", ifa.resp_rdata, 32'h0);
        chk("rst_we", {31'h0, ifa.mem_we}, 32'h0);
        chk("rst_bwe", {28'h0, ifa.mem_byte_we}, 32'h0);
        chk("rst_addr", {18'h0, ifa.mem_addr}, 32'h0);
        chk("rst_wdata", ifa.mem_wdata, 32'h0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        run("sw",   1, 3'b010, 32'h0100, 32'hDEADBEEF, 2, 32'h0, 0, 1, 4'b1111);
        chk("sw_addr_held", {18'h0, ifa.mem_addr}, 32'h0100);
        chk("sw_bwe_idle", {28'h0, ifa.mem_byte_we}, 32'h0);
        run("lb",   0, 3'b000, 32'h0103, 32'h0, 3, 32'hFFFFFFDE, 0, 0, 4'b0000);
        run("lbu",  0, 3'b100, 32'h0103, 32'h0, 3, 32'h000000DE, 0, 0, 4'b0000);
        run("lh",   0, 3'b001, 32'h0102, 32'h0, 3, 32'hFFFFDEAD, 0, 0, 4'b0000);
        run("lhu",  0, 3'b101, 32'h0102, 32'h0, 3, 32'h0000DEAD, 0, 0, 4'b0000);
        run("lw",   0, 3'b010, 32'h0100, 32'h0, 3, 32'hDEADBEEF, 0, 0, 4'b0000);
        run("ld011",0, 3'b011, 32'h0100, 32'h0, 1, 32'h0, 1, 0, 4'b0000);
        run("swoor",1, 3'b010, 32'h00010000, 32'h12345678, 1, 32'h0, 1, 0, 4'b0000);
        run("st100",1, 3'b100, 32'h0200, 32'h12345678, 1, 32'h0, 1, 0, 4'b0000);
        chk("err_addr_kept", {18'h0, ifa.mem_addr}, 32'h0100);
`ifdef LSU_MISALIGN_TRAP_EN
        run("lwmis",0, 3'b010, 32'h0102, 32'h0, 1, 32'h0, 1, 0, 4'b0000);
`else
        run("lwmis",0, 3'b010, 32'h0102, 32'h0, 3, 32'h0000DEAD, 0, 0, 4'b0000);
`endif
        run("sbtop",1, 3'b000, 32'h3FFF, 32'h0000005A, 2, 32'h0, 0, 1, 4'b0001);
        run("lbtop",0, 3'b000, 32'h3FFF, 32'h0, 3, 32'h0000005A, 0, 0, 4'b0000);
        run("sh",   1, 3'b001, 32'h0200, 32'h00018001, 2, 32'h0, 0, 1, 4'b0011);
        run("lhneg",0, 3'b001, 32'h0200, 32'h0, 3, 32'hFFFF8001, 0, 0, 4'b0000);
        run("lwsh", 0, 3'b010, 32'h0200, 32'h0, 3, 32'h00008001, 0, 0, 4'b0000);

        // RD_LAT=3: address held T+1..T+4, response at T+5.
        @(negedge clk);
        ifb.req_valid = 1; ifb.req_we = 0; ifb.req_funct3 = 3'b010; ifb.req_addr = 32'h0100;
        @(posedge clk);
        #1 ifb.req_valid = 0;
        lat = -1; addr_ok = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 4 && ifb.mem_addr != 14'h0100) addr_ok = 1'b0;
            if (ifb.resp_valid && lat < 0) begin
                lat = c;
                chk("b_rdata", ifb.resp_rdata, 32'hDEADBEEF);
            end
        end
        chk("b_lat", lat, 5);
        chk("b_addr_stable", {31'h0, addr_ok}, 32'h1);

        // Reset during WAIT drops the response.
        @(negedge clk);
        ifb.req_valid = 1; ifb.req_funct3 = 3'b010; ifb.req_addr = 32'h0104;
        @(posedge clk);
        #1 ifb.req_valid = 0;
        @(posedge clk);
        #1 rst_b_n = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("b_rst_addr", {18'h0, ifb.mem_addr}, 32'h0);
            if (c == 2) rst_b_n = 1'b1;
            if (ifb.resp_valid) cnt++;
        end
        chk("b_rst_noresp", cnt, 0);
        chk("b_rst_ready", {31'h0, ifb.req_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
